// File: rtl/note_sequencer.sv
// note_sequencer: keypad pattern recorder and fixed-tempo player.
// Define NOTE_SEQUENCER_LOOP_EN to loop playback forever instead of returning to IDLE.
module note_sequencer #(
   parameter int DEPTH  = 16,
   parameter int TICK_W = 24
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     key_valid_i,
   input  logic [3:0]               key_value_i,
   input  logic                     rec_start_i,
   input  logic                     play_start_i,
   input  logic                     stop_i,
   input  logic [TICK_W-1:0]        step_ticks_i,
   output logic [3:0]               note_o,
   output logic                     note_valid_o,
   output logic                     step_o,
   output logic [1:0]               state_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   typedef enum logic [1:0] {IDLE = 2'd0, RECORD = 2'd1, PLAY = 2'd2} state_t;
   state_t            state;
   logic [3:0]        mem [DEPTH];
   logic [AW-1:0]     idx, nxt_idx;
   logic [TICK_W-1:0] tick, first_tick;
   logic              wr_en, can_play, last;
   assign state_o    = state;
   assign wr_en      = state == RECORD && key_valid_i && !full_o && !stop_i && !rec_start_i;
   assign can_play   = (state == IDLE || state == PLAY) && count_o != '0;
   assign nxt_idx    = idx + AW'(1);
   assign last       = count_o == {1'b0, idx} + CW'(1);
   // a zero step length behaves as one cycle per note
   assign first_tick = (step_ticks_i == '0) ? '0 : step_ticks_i - TICK_W'(1);
   always_ff @(posedge clk_i)
      if (wr_en) mem[count_o[AW-1:0]] <= key_value_i;
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         state        <= IDLE;
         note_o       <= '0;
         note_valid_o <= 1'b0;
         step_o       <= 1'b0;
         count_o      <= '0;
         full_o       <= 1'b0;
         idx          <= '0;
         tick         <= '0;
      end else if (stop_i) begin
         state        <= IDLE;
         note_valid_o <= 1'b0;
         step_o       <= 1'b0;
      end else if (rec_start_i) begin
         state        <= RECORD;
         count_o      <= '0;
         full_o       <= 1'b0;
         note_valid_o <= 1'b0;
         step_o       <= 1'b0;
      end else if (play_start_i && can_play) begin
         state        <= PLAY;
         idx          <= '0;
         tick         <= first_tick;
         note_o       <= mem[0];
         note_valid_o <= 1'b1;
         step_o       <= 1'b1;
      end else if (state == RECORD) begin
         if (wr_en) begin
            count_o <= count_o + CW'(1);
            full_o  <= count_o == CW'(DEPTH - 1);
            note_o  <= key_value_i;
         end
      end else if (state == PLAY) begin
         if (tick != '0) begin
            tick   <= tick - TICK_W'(1);
            step_o <= 1'b0;
         end else begin
`ifdef NOTE_SEQUENCER_LOOP_EN
            idx    <= last ? '0 : nxt_idx;
            note_o <= last ? mem[0] : mem[nxt_idx];
            tick   <= first_tick;
            step_o <= 1'b1;
`else
            idx          <= nxt_idx;
            note_o       <= last ? note_o : mem[nxt_idx];
            tick         <= first_tick;
            step_o       <= !last;
            note_valid_o <= !last;
            state        <= last ? IDLE : PLAY;
`endif
         end
      end
endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 Parameter DEPTH, default 16, number of stored note slots (power of two, 2..64).
REQ-002 Parameter TICK_W, default 24, width of the step-length tick count.
REQ-003 clk_i  in  1  sole clock, rising edge; the 12 MHz synth clock domain.
REQ-004 rst_ni  in  1  reset, asynchronous assert, active-low.
REQ-005 key_valid_i  in  1  one-cycle pulse: decoded keypad press available.
REQ-006 key_value_i  in  4  keypad code, valid with key_valid_i.
REQ-007 rec_start_i  in  1  one-cycle pulse: begin recording a new pattern.
REQ-008 play_start_i  in  1  one-cycle pulse: begin playback from slot 0.
REQ-009 stop_i  in  1  one-cycle pulse: return to IDLE.
REQ-010 step_ticks_i  in  TICK_W  clk_i cycles per playback step.
REQ-011 note_o  out  4  key code for the downstream decoder/divider chain.
REQ-012 note_valid_o  out  1  high while note_o is a playing note (audio gate).
REQ-013 step_o  out  1  one-cycle pulse at every new note in PLAY.
REQ-014 state_o  out  2  0=IDLE, 1=RECORD, 2=PLAY.
REQ-015 count_o  out  $clog2(DEPTH)+1  number of recorded notes.
REQ-016 full_o  out  1  high when count_o==DEPTH.

Function
REQ-017 FSM states IDLE, RECORD, PLAY; all outputs registered.
REQ-018 Command priority each cycle: stop_i > rec_start_i > play_start_i; lower commands ignored that cycle.
REQ-019 stop_i in any state -> IDLE next cycle; count_o and memory contents retained.
REQ-020 IDLE + rec_start_i -> RECORD next cycle, count_o cleared to 0 in the same edge.
REQ-021 RECORD + key_valid_i with count_o<DEPTH: write key_value_i to slot count_o, count_o+1 next cycle, note_o=key_value_i next cycle.
REQ-022 RECORD + key_valid_i with full_o=1: write dropped, count_o unchanged, stays in RECORD.
REQ-023 RECORD + rec_start_i: restart recording, count_o cleared to 0.
REQ-024 IDLE + play_start_i with count_o>0 -> PLAY next cycle; note_o=slot 0, note_valid_o=1, step_o=1 that cycle.
REQ-025 IDLE + play_start_i with count_o==0: ignored, stays in IDLE.
REQ-026 play_start_i in PLAY restarts at slot 0 (same outputs as REQ-024); rec_start_i in PLAY -> RECORD per REQ-020.
REQ-027 Each PLAY step lasts exactly max(step_ticks_i,1) cycles; step_ticks_i sampled at step start, changes mid-step take effect next step.
REQ-028 At step end, index+1; next note presented on the following cycle with step_o=1.
REQ-029 Step end at index count_o-1: wrap behaviour per Configuration.
REQ-030 note_valid_o=0 in IDLE and RECORD; step_o=0 outside PLAY.
REQ-031 note_o holds its last value on leaving PLAY or RECORD.

Reset
REQ-032 rst_ni low: state IDLE, note_o=0, note_valid_o=0, step_o=0, count_o=0, full_o=0, tick counter and index 0, immediately (asynchronous).
REQ-033 Reset mid-PLAY or mid-RECORD aborts without completing the step/write; memory contents undefined after reset (count_o=0 makes them unreachable).

Configuration
REQ-034 Macro NOTE_SEQUENCER_LOOP_EN defined: at last-slot step end, index wraps to 0 and PLAY continues indefinitely.
REQ-035 Macro undefined: at last-slot step end, FSM -> IDLE, note_valid_o=0 next cycle, no step_o pulse.

Verification
REQ-036 Reset, rec_start_i, keys 3,7,1, stop_i -> count_o=3, state_o=0, note_o=1.
REQ-037 Record 17 keys with DEPTH=16 -> full_o=1 after 16th, count_o=16, 17th ignored.
REQ-038 Pattern 3,7,1, step_ticks_i=4, play_start_i -> note_o 3,7,1 each 4 cycles, step_o every 4 cycles; LOOP_EN: 3 repeats; else IDLE after 12 cycles.
REQ-039 step_ticks_i=0 in PLAY -> new note every cycle, step_o held high.
REQ-040 stop_i, rec_start_i, play_start_i same cycle in PLAY -> IDLE, count_o unchanged.
REQ-041 rst_ni low mid-step of PLAY -> all outputs zero without waiting for clk_i edge; play_start_i after reset ignored (count_o=0).
